mul_share_arbiter: RTL and testbench
====================================

Name: mul_share_arbiter

Overview:
Shares one combinational 32x32 signed Booth multiplier (booth_mul: A, B -> 64-bit Product) between two requester ports. Each port uses a valid/ready handshake. Arbitration is round-robin. Operands and product are registered, and the product is sampled after a configurable settle time. Each result is returned only to the port that issued it. The block sits between the ALU issue logic and the multiplier datapath.

Parameters:
EXEC_CYCLES, 1, number of cycles operands are held on booth_mul before Product is sampled (multicycle-path budget); values below 1 behave as 1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid_0  input  1  port 0 has an operation pending
req_ready_0  output  1  port 0 operation accepted this cycle
a_0  input  32  port 0 multiplicand, two's complement
b_0  input  32  port 0 multiplier, two's complement
resp_valid_0  output  1  port 0 product available
resp_ready_0  input  1  port 0 consumes product
product_0  output  64  port 0 signed product
req_valid_1, req_ready_1, a_1, b_1, resp_valid_1, resp_ready_1, product_1: same as port 0, for port 1
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE; operand regs=0; result reg=0; owner=0; last_grant=1, so port 0 wins the first tie; exec counter=0.
- Reset values of outputs: all req_ready_x, resp_valid_x and busy are 0; product_x are 0.
- Reset mid-operation aborts the operation. No response is ever issued for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE, grant selection:
  - Only one port valid: that port is granted.
  - Both ports valid: the port != last_grant is granted.
  - req_ready_x is combinational. It is 1 only in IDLE, for the granted port, while that port's req_valid_x is 1.
- IDLE, on the accepting edge: capture a_x/b_x into the operand regs, owner=x, counter=EXEC_CYCLES-1, go to EXEC.
- Requesters hold valid and data stable until ready. Deasserting valid before ready is allowed; the request is simply not taken.
- EXEC:
  - Operand regs drive booth_mul.
  - If counter != 0, decrement it.
  - If counter == 0, latch Product into the result reg and go to RESP.
- RESP:
  - resp_valid_owner=1. product_owner=result reg.
  - The non-owner port has resp_valid=0 and product=0.
  - On resp_ready_owner=1: last_grant=owner, go to IDLE.
  - Backpressure: the block holds in RESP indefinitely, with result stable.
- Latency: resp_valid rises EXEC_CYCLES clock edges after the accepting edge.
- Throughput: the earliest next acceptance is the cycle after the response handshake. The minimum period is EXEC_CYCLES+2 cycles.
- No ready is asserted outside IDLE. A request arriving during EXEC or RESP waits.
- Arithmetic: full 64-bit signed product, no truncation or saturation. -2^31 * -2^31 = 64'h4000_0000_0000_0000.
- Simultaneous events: in the RESP handshake cycle both ports may already be valid. Grant happens in the following IDLE cycle and uses the updated last_grant.
- resp_ready_x of the non-owner port is ignored.

Test Plan:
- Reset then single op: port 0 A=20, B=-3 -> req_ready_0 high 1 cycle; resp_valid_0 asserted after EXEC_CYCLES edges with product_0=64'hFFFF_FFFF_FFFF_FFC4; resp_valid_1 stays 0.
- Contention: both valid from reset, port 0 A=77, B=88 and port 1 A=-90, B=-90 -> port 0 served first (6776); then port 1 (8100); then, with port 0 revalidated as A=-100, B=99, port 0 gets -9900. Grant order 0,1,0.
- Backpressure: port 1 A=-200, B=4008 with resp_ready_1=0 for 5 cycles -> product_1=-801600 held stable; busy=1; no req_ready_0 despite req_valid_0=1; after ready, returns to IDLE in 1 cycle.
- EXEC_CYCLES=3: port 0 A=-111, B=-2222 -> resp_valid_0 rises exactly 3 edges after accept; product 246642.
- Corners: A=0, B=98765 -> 0; A=1, B=98765 -> 98765; A=B=32'h8000_0000 -> 64'h4000_0000_0000_0000.
- Reset during EXEC (rst_n low for 1 cycle) -> all outputs 0 immediately; no response; next op is accepted normally, with port 0 winning the tie.

Source files
------------

// File: rtl/mul_share_arbiter.sv
// Two-port round-robin front end for a single shared 32x32 signed multiplier.
// Operands are registered and the product is sampled after EXEC_CYCLES cycles.

module booth_mul (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] product
);
   logic [32:0] b_ext;
   logic [63:0] a_ext;
   logic [63:0] a_ext2;
   logic [63:0] pp [16];

   assign b_ext  = {b, 1'b0};
   assign a_ext  = {{32{a[31]}}, a};
   assign a_ext2 = a_ext << 1;

   // Radix-4 recoding: each bit triplet selects 0, +/-A or +/-2A at weight 4^gi.
   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_pp
         logic [2:0]  trip;
         logic [63:0] mag;
         assign trip = b_ext[2*gi+2 : 2*gi];
         always_comb begin
            case (trip)
               3'b001, 3'b010: mag = a_ext;
               3'b011:         mag = a_ext2;
               3'b100:         mag = -a_ext2;
               3'b101, 3'b110: mag = -a_ext;
               default:        mag = '0;
            endcase
         end
         assign pp[gi] = mag << (2 * gi);
      end
   endgenerate

   always_comb begin
      product = '0;
      for (int i = 0; i < 16; i++) begin
         product = product + pp[i];
      end
   end
endmodule

module mul_share_arbiter #(
   parameter int EXEC_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid_0,
   output logic        req_ready_0,
   input  logic [31:0] a_0,
   input  logic [31:0] b_0,
   output logic        resp_valid_0,
   input  logic        resp_ready_0,
   output logic [63:0] product_0,
   input  logic        req_valid_1,
   output logic        req_ready_1,
   input  logic [31:0] a_1,
   input  logic [31:0] b_1,
   output logic        resp_valid_1,
   input  logic        resp_ready_1,
   output logic [63:0] product_1,
   output logic        busy
);
   localparam int EXEC_EFF = (EXEC_CYCLES < 1) ? 1 : EXEC_CYCLES;
   localparam int CNT_W    = (EXEC_EFF > 1) ? $clog2(EXEC_EFF) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_EFF - 1);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t             state_q, state_d;
   logic [31:0]        a_q, a_d, b_q, b_d;
   logic [63:0]        result_q, result_d;
   logic               owner_q, owner_d;
   logic               last_grant_q, last_grant_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [63:0]        mul_p;
   logic               grant_port;
   logic               accept;
   logic               resp_hs;

   booth_mul u_mul (
      .a       (a_q),
      .b       (b_q),
      .product (mul_p)
   );

   // On a tie the port that did not win last time is served.
   always_comb begin
      grant_port = (req_valid_0 & req_valid_1) ? ~last_grant_q : req_valid_1;
      accept     = (state_q == IDLE) & (req_valid_0 | req_valid_1);
      resp_hs    = (state_q == RESP) & (owner_q ? resp_ready_1 : resp_ready_0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         a_q          <= '0;
         b_q          <= '0;
         result_q     <= '0;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         a_q          <= a_d;
         b_q          <= b_d;
         result_q     <= result_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = EXEC;
         EXEC:    if (cnt_q == '0) state_d = RESP;
         RESP:    if (resp_hs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      a_d          = a_q;
      b_d          = b_q;
      result_d     = result_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      if (accept) begin
         a_d     = grant_port ? a_1 : a_0;
         b_d     = grant_port ? b_1 : b_0;
         owner_d = grant_port;
         cnt_d   = CNT_LOAD;
      end
      if (state_q == EXEC) begin
         if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
         else             result_d = mul_p;
      end
      if (resp_hs) last_grant_d = owner_q;
   end

   // Ready is also masked by reset so every output reads 0 while rst_n is low.
   always_comb begin
      req_ready_0  = rst_n & (state_q == IDLE) & req_valid_0 & ~grant_port;
      req_ready_1  = rst_n & (state_q == IDLE) & req_valid_1 & grant_port;
      resp_valid_0 = (state_q == RESP) & ~owner_q;
      resp_valid_1 = (state_q == RESP) & owner_q;
      product_0    = resp_valid_0 ? result_q : '0;
      product_1    = resp_valid_1 ? result_q : '0;
      busy         = (state_q != IDLE);
   end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter: one instance with EXEC_CYCLES=1, one with 3.
module tb_mul_share_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid_0 = 0, req_valid_1 = 0, resp_ready_0 = 0, resp_ready_1 = 0;
   logic [31:0] a_0 = 0, b_0 = 0, a_1 = 0, b_1 = 0;
   logic        req_ready_0, req_ready_1, resp_valid_0, resp_valid_1, busy;
   logic [63:0] product_0, product_1;

   logic        x_req_valid_0 = 0, x_resp_ready_0 = 0;
   logic [31:0] x_a_0 = 0, x_b_0 = 0;
   logic        x_req_ready_0, x_req_ready_1, x_resp_valid_0, x_resp_valid_1, x_busy;
   logic [63:0] x_product_0, x_product_1;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   mul_share_arbiter #(.EXEC_CYCLES(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .a_0(a_0), .b_0(b_0),
      .resp_valid_0(resp_valid_0), .resp_ready_0(resp_ready_0), .product_0(product_0),
      .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .a_1(a_1), .b_1(b_1),
      .resp_valid_1(resp_valid_1), .resp_ready_1(resp_ready_1), .product_1(product_1),
      .busy(busy)
   );

   mul_share_arbiter #(.EXEC_CYCLES(3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .req_valid_0(x_req_valid_0), .req_ready_0(x_req_ready_0), .a_0(x_a_0), .b_0(x_b_0),
      .resp_valid_0(x_resp_valid_0), .resp_ready_0(x_resp_ready_0), .product_0(x_product_0),
      .req_valid_1(1'b0), .req_ready_1(x_req_ready_1), .a_1(32'd0), .b_1(32'd0),
      .resp_valid_1(x_resp_valid_1), .resp_ready_1(1'b0), .product_1(x_product_1),
      .busy(x_busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %-22s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_ready0", {63'd0, req_ready_0}, 64'd0);
      chk("rst_ready1", {63'd0, req_ready_1}, 64'd0);
      chk("rst_rvalid0", {63'd0, resp_valid_0}, 64'd0);
      chk("rst_rvalid1", {63'd0, resp_valid_1}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_prod0", product_0, 64'd0);
      chk("rst_prod1", product_1, 64'd0);
      tick(); rst_n = 1'b1;

      // Single op on port 0
      tick();
      req_valid_0 = 1; a_0 = 32'd20; b_0 = -32'sd3; #1;
      chk("t1_ready0", {63'd0, req_ready_0}, 64'd1);
      chk("t1_ready1", {63'd0, req_ready_1}, 64'd0);
      tick(); req_valid_0 = 0; #1;
      chk("t1_ready0_after", {63'd0, req_ready_0}, 64'd0);
      chk("t1_busy", {63'd0, busy}, 64'd1);
      chk("t1_rvalid0_early", {63'd0, resp_valid_0}, 64'd0);
      tick();
      chk("t1_rvalid0", {63'd0, resp_valid_0}, 64'd1);
      chk("t1_prod0", product_0, 64'hFFFF_FFFF_FFFF_FFC4);
      chk("t1_rvalid1", {63'd0, resp_valid_1}, 64'd0);
      chk("t1_prod1", product_1, 64'd0);
      resp_ready_0 = 1;
      tick(); resp_ready_0 = 0;
      chk("t1_idle", {63'd0, busy}, 64'd0);
      chk("t1_rvalid0_off", {63'd0, resp_valid_0}, 64'd0);

      // Contention after a fresh reset: grant order 0,1,0
      rst_n = 0; tick(); rst_n = 1;
      req_valid_0 = 1; a_0 = 32'd77; b_0 = 32'd88;
      req_valid_1 = 1; a_1 = -32'sd90; b_1 = -32'sd90; #1;
      chk("c_ready0", {63'd0, req_ready_0}, 64'd1);
      chk("c_ready1", {63'd0, req_ready_1}, 64'd0);
      tick(); req_valid_0 = 0;
      tick();
      chk("c_prod0", product_0, 64'd6776);
      chk("c_ready1_resp", {63'd0, req_ready_1}, 64'd0);
      resp_ready_0 = 1;
      tick(); resp_ready_0 = 0;
      req_valid_0 = 1; a_0 = -32'sd100; b_0 = 32'd99; #1;
      chk("c_ready1_2nd", {63'd0, req_ready_1}, 64'd1);
      chk("c_ready0_2nd", {63'd0, req_ready_0}, 64'd0);
      tick(); req_valid_1 = 0;
      tick();
      chk("c_prod1", product_1, 64'd8100);
      chk("c_rvalid0", {63'd0, resp_valid_0}, 64'd0);
      resp_ready_1 = 1;
      tick(); resp_ready_1 = 0; #1;
      chk("c_ready0_3rd", {63'd0, req_ready_0}, 64'd1);
      tick(); req_valid_0 = 0;
      tick();
      chk("c_prod0_3rd", product_0, -64'sd9900);
      resp_ready_0 = 1;
      tick(); resp_ready_0 = 0;

      // Backpressure on port 1, port 0 waiting with first corner operands
      req_valid_1 = 1; a_1 = -32'sd200; b_1 = 32'd4008;
      req_valid_0 = 1; a_0 = 32'd0; b_0 = 32'd98765; #1;
      chk("bp_ready1", {63'd0, req_ready_1}, 64'd1);
      tick(); req_valid_1 = 0;
      tick();
      resp_ready_0 = 1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_prod1", product_1, -64'sd801600);
         chk("bp_rvalid1", {63'd0, resp_valid_1}, 64'd1);
         chk("bp_busy", {63'd0, busy}, 64'd1);
         chk("bp_ready0", {63'd0, req_ready_0}, 64'd0);
         tick();
      end
      resp_ready_0 = 0; resp_ready_1 = 1;
      tick(); resp_ready_1 = 0; #1;
      chk("bp_idle", {63'd0, busy}, 64'd0);
      chk("bp_ready0_after", {63'd0, req_ready_0}, 64'd1);

      // Corners on port 0
      tick(); a_0 = 32'd1; b_0 = 32'd98765;
      tick();
      chk("k_zero", product_0, 64'd0);
      resp_ready_0 = 1;
      tick(); resp_ready_0 = 0; #1;
      chk("k_ready_one", {63'd0, req_ready_0}, 64'd1);
      tick(); a_0 = 32'h8000_0000; b_0 = 32'h8000_0000;
      tick();
      chk("k_one", product_0, 64'd98765);
      resp_ready_0 = 1;
      tick(); resp_ready_0 = 0; #1;
      chk("k_ready_min", {63'd0, req_ready_0}, 64'd1);
      tick(); req_valid_0 = 0;
      tick();
      chk("k_minmin", product_0, 64'h4000_0000_0000_0000);
      resp_ready_0 = 1;
      tick(); resp_ready_0 = 0;

      // Reset during EXEC; both ports valid afterwards
      req_valid_0 = 1; a_0 = 32'd5; b_0 = 32'd7;
      tick(); req_valid_1 = 1; a_1 = 32'd3; b_1 = 32'd3; #1;
      chk("r_busy_exec", {63'd0, busy}, 64'd1);
      rst_n = 0; #1;
      chk("r_busy", {63'd0, busy}, 64'd0);
      chk("r_rvalid0", {63'd0, resp_valid_0}, 64'd0);
      chk("r_ready0", {63'd0, req_ready_0}, 64'd0);
      chk("r_ready1", {63'd0, req_ready_1}, 64'd0);
      tick(); rst_n = 1; #1;
      chk("r_no_resp", {63'd0, resp_valid_0}, 64'd0);
      chk("r_tie_ready0", {63'd0, req_ready_0}, 64'd1);
      chk("r_tie_ready1", {63'd0, req_ready_1}, 64'd0);
      tick(); req_valid_0 = 0; req_valid_1 = 0;
      tick();
      chk("r_prod0", product_0, 64'd35);
      resp_ready_0 = 1;
      tick(); resp_ready_0 = 0;

      // EXEC_CYCLES=3 latency
      x_req_valid_0 = 1; x_a_0 = -32'sd111; x_b_0 = -32'sd2222; #1;
      chk("e3_ready", {63'd0, x_req_ready_0}, 64'd1);
      tick(); x_req_valid_0 = 0;
      chk("e3_edge1_pre", {63'd0, x_resp_valid_0}, 64'd0);
      tick();
      chk("e3_edge2", {63'd0, x_resp_valid_0}, 64'd0);
      tick();
      chk("e3_edge3_early", {63'd0, x_resp_valid_0}, 64'd0);
      tick();
      chk("e3_rvalid", {63'd0, x_resp_valid_0}, 64'd1);
      chk("e3_prod", x_product_0, 64'd246642);
      x_resp_ready_0 = 1;
      tick(); x_resp_ready_0 = 0;
      chk("e3_idle", {63'd0, x_busy}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
